riscv_inst_checker: RTL and testbench
=====================================

// Module: riscv_inst_checker
// PURPOSE
//   Synthesizable, table-driven self-check block for RISCV_TOP runs. It watches NUM_INST/OUTPUT_PORT/HALT
//   and compares OUTPUT_PORT against an expected value at each listed retired-instruction count.
//   It reports pass/fail/timeout and cycle count in hardware, so test benches and FPGA builds share one checker.
//   Generalises per-program test tables: test count, data width, timeout, stop-on-fail mode.
// PARAMETERS
//   NUM_TEST      17        number of table entries (1..2**IDX_W)
//   IDX_W         5         entry index width
//   DATA_W        32        width of NUM_INST, OUTPUT_PORT, expected values
//   CYC_W         32        cycle counter width
//   TIMEOUT       1000000   RUN cycles before timeout; 0 disables timeout
//   STOP_ON_FAIL  1         1: go DONE on first mismatch; 0: keep checking, first failure held
// PORTS
//   CLK          in   1        clock, all logic on rising edge
//   RSTn         in   1        synchronous active-low reset
//   TBL_WE       in   1        table write strobe (honoured in IDLE/DONE only)
//   TBL_IDX      in   IDX_W    entry written; idx >= NUM_TEST ignored
//   TBL_NUM_INST in   DATA_W   instruction count at which entry is checked
//   TBL_ANS      in   DATA_W   expected OUTPUT_PORT value
//   START        in   1        1-cycle pulse: begin run (IDLE/DONE only)
//   NUM_INST     in   DATA_W   retired instruction count from core
//   OUTPUT_PORT  in   DATA_W   core output port
//   HALT         in   1        core halt indication
//   BUSY         out  1        state==RUN
//   DONE         out  1        state==DONE
//   PASS         out  1        run ended by HALT, no mismatch, every valid entry checked
//   FAIL         out  1        mismatch seen (sticky until START/reset)
//   MISS         out  1        HALT reached with a valid entry never checked
//   TIMED_OUT    out  1        run ended by timeout
//   FAIL_IDX     out  IDX_W    index of first mismatching entry (lowest index if several same cycle)
//   FAIL_VAL     out  DATA_W   OUTPUT_PORT sampled at that first mismatch
//   PASS_CNT     out  IDX_W+1  number of entries checked and matched
//   CYCLE        out  CYC_W    RUN cycles elapsed; frozen in DONE, saturates at all-ones
// BEHAVIOUR
//   - Reset (RSTn=0 at edge): state IDLE; table entries {num_inst, ans, valid, checked} all cleared.
//     All outputs 0. Reset mid-RUN aborts immediately; no partial status survives.
//   - Table write: at edge with TBL_WE=1 in IDLE/DONE, entry[TBL_IDX] <= {TBL_NUM_INST, TBL_ANS}, valid=1.
//     Ignored during RUN. Write and START in the same cycle: write lands first, so the run sees it.
//   - FSM: IDLE -START-> RUN; RUN -(HALT | timeout | fail&STOP_ON_FAIL)-> DONE; DONE -START-> RUN.
//     START clears checked flags, FAIL/MISS/PASS/TIMED_OUT, FAIL_IDX/VAL, PASS_CNT, CYCLE. Table is kept.
//     START during RUN is ignored.
//   - RUN, every cycle: CYCLE += 1 (saturating). For each valid, unchecked entry with NUM_INST == num_inst:
//     set checked. If OUTPUT_PORT == ans, PASS_CNT += 1; else record a mismatch.
//     Several entries may match in one cycle; all are evaluated and PASS_CNT adds the count.
//   - First mismatch only: FAIL=1, FAIL_IDX/FAIL_VAL latched; later mismatches leave them unchanged.
//   - Timeout: TIMEOUT != 0 and CYCLE == TIMEOUT-1 in RUN -> DONE with TIMED_OUT=1.
//   - Priority in one cycle: comparisons are applied first, then HALT, then timeout. HALT with timeout gives TIMED_OUT=0.
//   - On HALT exit: MISS=1 if any valid entry is unchecked. PASS = !FAIL & !MISS.
//   - Latency: all status is registered and visible the cycle after the sampling edge.
//   - Empty table (no valid entries) + HALT -> PASS=1, PASS_CNT=0.
// TESTING
//   T1 table {4:0x0eec, 6:0x0000, 0x46:0x0000}, core drives matching values, HALT at NUM_INST 0x46
//      -> DONE=1, PASS=1, PASS_CNT=3, FAIL=0.
//   T2 same table, OUTPUT_PORT=0x0eed at NUM_INST 4, STOP_ON_FAIL=1
//      -> next cycle DONE=1, FAIL=1, FAIL_IDX=0, FAIL_VAL=0x0eed, PASS=0.
//   T3 STOP_ON_FAIL=0, mismatches at entries 1 and 2
//      -> BUSY stays 1 until HALT, FAIL_IDX=1, PASS_CNT=1, PASS=0.
//   T4 TIMEOUT=20, no HALT -> DONE at CYCLE=19, TIMED_OUT=1; TIMEOUT=20 with HALT at cycle 19 -> TIMED_OUT=0.
//   T5 two entries with num_inst 0x10, both expecting 0x1; HALT with entry 0x21 unseen
//      -> PASS_CNT=2, MISS=1, PASS=0.
//   T6 RSTn=0 mid-RUN -> next cycle all outputs 0, state IDLE. Then TBL_WE during RUN is dropped,
//      and START in DONE reruns with CYCLE restarting from 0.

Source files
------------

// File: rtl/riscv_inst_checker.sv
// Table-driven self-check block for RISCV_TOP runs: compares OUTPUT_PORT with the
// expected answer at each listed retired-instruction count, and reports
// pass/fail/miss/timeout plus the number of RUN cycles.
module riscv_inst_checker #(
    parameter int NUM_TEST     = 17,
    parameter int IDX_W        = 5,
    parameter int DATA_W       = 32,
    parameter int CYC_W        = 32,
    parameter int TIMEOUT      = 1000000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              TBL_WE,
    input  logic [IDX_W-1:0]  TBL_IDX,
    input  logic [DATA_W-1:0] TBL_NUM_INST,
    input  logic [DATA_W-1:0] TBL_ANS,
    input  logic              START,
    input  logic [DATA_W-1:0] NUM_INST,
    input  logic [DATA_W-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              FAIL,
    output logic              MISS,
    output logic              TIMED_OUT,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DATA_W-1:0] FAIL_VAL,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [CYC_W-1:0]  CYCLE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CYC_W-1:0] TO_LIM = CYC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    logic [DATA_W-1:0] tbl_num [NUM_TEST];
    logic [DATA_W-1:0] tbl_ans [NUM_TEST];
    logic [NUM_TEST-1:0] tbl_valid;
    logic [NUM_TEST-1:0] tbl_checked;

    logic [NUM_TEST-1:0] hit;
    logic [IDX_W:0]      ok_cnt;
    logic                any_bad;
    logic [IDX_W-1:0]    bad_idx;
    logic                unseen;
    logic [CYC_W-1:0]    cyc_next;
    logic                timeout_hit;

    assign BUSY = (state == S_RUN);
    assign DONE = (state == S_DONE);

    // Evaluate every table entry against the current core outputs; the first
    // mismatch found while scanning upward is the lowest index.
    always_comb begin
        hit     = '0;
        ok_cnt  = '0;
        any_bad = 1'b0;
        bad_idx = '0;
        for (int unsigned i = 0; i < NUM_TEST; i++) begin
            hit[i] = tbl_valid[i] & ~tbl_checked[i] & (NUM_INST == tbl_num[i]);
            if (hit[i]) begin
                if (OUTPUT_PORT == tbl_ans[i]) begin
                    ok_cnt = ok_cnt + (IDX_W+1)'(1);
                end else begin
                    if (!any_bad) bad_idx = IDX_W'(i);
                    any_bad = 1'b1;
                end
            end
        end
        unseen      = |(tbl_valid & ~(tbl_checked | hit));
        cyc_next    = (CYCLE == '1) ? CYCLE : CYCLE + CYC_W'(1);
        timeout_hit = (TIMEOUT != 0) && (cyc_next >= TO_LIM);
    end

    // Control FSM, expectation table and registered status.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state       <= S_IDLE;
            tbl_valid   <= '0;
            tbl_checked <= '0;
            for (int unsigned i = 0; i < NUM_TEST; i++) begin
                tbl_num[i] <= '0;
                tbl_ans[i] <= '0;
            end
            PASS      <= 1'b0;
            FAIL      <= 1'b0;
            MISS      <= 1'b0;
            TIMED_OUT <= 1'b0;
            FAIL_IDX  <= '0;
            FAIL_VAL  <= '0;
            PASS_CNT  <= '0;
            CYCLE     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Indices at or beyond NUM_TEST match no entry and are dropped.
                    for (int unsigned i = 0; i < NUM_TEST; i++) begin
                        if (TBL_WE && (TBL_IDX == IDX_W'(i))) begin
                            tbl_num[i]     <= TBL_NUM_INST;
                            tbl_ans[i]     <= TBL_ANS;
                            tbl_valid[i]   <= 1'b1;
                            tbl_checked[i] <= 1'b0;
                        end
                    end
                    if (START) begin
                        state       <= S_RUN;
                        tbl_checked <= '0;
                        PASS        <= 1'b0;
                        FAIL        <= 1'b0;
                        MISS        <= 1'b0;
                        TIMED_OUT   <= 1'b0;
                        FAIL_IDX    <= '0;
                        FAIL_VAL    <= '0;
                        PASS_CNT    <= '0;
                        CYCLE       <= '0;
                    end
                end
                S_RUN: begin
                    CYCLE       <= cyc_next;
                    tbl_checked <= tbl_checked | hit;
                    PASS_CNT    <= PASS_CNT + ok_cnt;
                    if (any_bad && !FAIL) begin
                        FAIL     <= 1'b1;
                        FAIL_IDX <= bad_idx;
                        FAIL_VAL <= OUTPUT_PORT;
                    end
                    // This cycle's comparisons feed the HALT verdict; HALT beats timeout.
                    if (HALT) begin
                        state <= S_DONE;
                        MISS  <= unseen;
                        PASS  <= ~(FAIL | any_bad) & ~unseen;
                    end else if (timeout_hit) begin
                        state     <= S_DONE;
                        TIMED_OUT <= 1'b1;
                    end else if ((STOP_ON_FAIL != 0) && any_bad) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_inst_checker.sv
module tb_riscv_inst_checker;

    localparam int NT = 3;
    localparam int IW = 2;
    localparam int DW = 16;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          TBL_WE;
    logic [IW-1:0] TBL_IDX;
    logic [DW-1:0] TBL_NUM_INST;
    logic [DW-1:0] TBL_ANS;
    logic          START;
    logic [DW-1:0] NUM_INST;
    logic [DW-1:0] OUTPUT_PORT;
    logic          HALT;

    // DUT a: stop on fail, TIMEOUT 20
    logic a_busy, a_done, a_pass, a_fail, a_miss, a_to;
    logic [IW-1:0] a_fidx;
    logic [DW-1:0] a_fval;
    logic [IW:0]   a_pcnt;
    logic [CW-1:0] a_cyc;
    // DUT b: keep checking, no timeout
    logic b_busy, b_done, b_pass, b_fail, b_miss, b_to;
    logic [IW-1:0] b_fidx;
    logic [DW-1:0] b_fval;
    logic [IW:0]   b_pcnt;
    logic [CW-1:0] b_cyc;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    riscv_inst_checker #(.NUM_TEST(NT), .IDX_W(IW), .DATA_W(DW), .CYC_W(CW),
                         .TIMEOUT(20), .STOP_ON_FAIL(1)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
        .TBL_NUM_INST(TBL_NUM_INST), .TBL_ANS(TBL_ANS), .START(START),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .FAIL(a_fail), .MISS(a_miss),
        .TIMED_OUT(a_to), .FAIL_IDX(a_fidx), .FAIL_VAL(a_fval), .PASS_CNT(a_pcnt),
        .CYCLE(a_cyc));

    riscv_inst_checker #(.NUM_TEST(NT), .IDX_W(IW), .DATA_W(DW), .CYC_W(CW),
                         .TIMEOUT(0), .STOP_ON_FAIL(0)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
        .TBL_NUM_INST(TBL_NUM_INST), .TBL_ANS(TBL_ANS), .START(START),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .FAIL(b_fail), .MISS(b_miss),
        .TIMED_OUT(b_to), .FAIL_IDX(b_fidx), .FAIL_VAL(b_fval), .PASS_CNT(b_pcnt),
        .CYCLE(b_cyc));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [DW-1:0] num, input logic [DW-1:0] ans);
        TBL_WE = 1'b1; TBL_IDX = idx; TBL_NUM_INST = num; TBL_ANS = ans;
        tick();
        TBL_WE = 1'b0;
    endtask

    task automatic start_run();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic drive(input logic [DW-1:0] n, input logic [DW-1:0] o, input logic h);
        NUM_INST = n; OUTPUT_PORT = o; HALT = h;
        tick();
        HALT = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; TBL_WE = 1'b0; TBL_IDX = '0; TBL_NUM_INST = '0; TBL_ANS = '0;
        START = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
        tick(); tick();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_cycle", a_cyc, 0);
        RSTn = 1'b1;

        // T1: all entries match; idx 3 is out of range and must be ignored
        wr(0, 16'h0004, 16'h0eec);
        wr(1, 16'h0006, 16'h0000);
        wr(2, 16'h0046, 16'h0000);
        wr(3, 16'h0099, 16'h0055);
        start_run();
        chk("t1_busy", a_busy, 1);
        chk("t1_cyc0", a_cyc, 0);
        drive(16'h0004, 16'h0eec, 0);
        chk("t1_pcnt1", a_pcnt, 1);
        chk("t1_cyc1", a_cyc, 1);
        drive(16'h0006, 16'h0000, 0);
        drive(16'h0020, 16'h1234, 0);
        drive(16'h0046, 16'h0000, 1);
        chk("t1_done", a_done, 1);
        chk("t1_busy0", a_busy, 0);
        chk("t1_pass", a_pass, 1);
        chk("t1_pcnt", a_pcnt, 3);
        chk("t1_fail", a_fail, 0);
        chk("t1_miss", a_miss, 0);
        chk("t1_to", a_to, 0);
        chk("t1_cyc", a_cyc, 4);
        chk("t1_b_pass", b_pass, 1);
        tick();
        chk("t1_cyc_frozen", a_cyc, 4);

        // T2: mismatch at entry 0 with stop-on-fail
        drive(16'h0000, 16'h0000, 0);
        start_run();
        drive(16'h0004, 16'h0eed, 0);
        chk("t2_done", a_done, 1);
        chk("t2_fail", a_fail, 1);
        chk("t2_fidx", a_fidx, 0);
        chk("t2_fval", a_fval, 16'h0eed);
        chk("t2_pass", a_pass, 0);
        chk("t2_b_busy", b_busy, 1);
        drive(16'h0000, 16'h0000, 1);
        chk("t2_b_done", b_done, 1);
        chk("t2_b_miss", b_miss, 1);
        chk("t2_b_pass", b_pass, 0);

        // T3: keep-checking mode, mismatches at entries 1 and 2
        start_run();
        drive(16'h0004, 16'h0eec, 0);
        drive(16'h0006, 16'h0bad, 0);
        chk("t3_busy_a", b_busy, 1);
        chk("t3_fidx_a", b_fidx, 1);
        drive(16'h0046, 16'h0777, 0);
        chk("t3_busy_b", b_busy, 1);
        chk("t3_fval_held", b_fval, 16'h0bad);
        drive(16'h0050, 16'h0000, 1);
        chk("t3_done", b_done, 1);
        chk("t3_fidx", b_fidx, 1);
        chk("t3_pcnt", b_pcnt, 1);
        chk("t3_pass", b_pass, 0);
        chk("t3_miss", b_miss, 0);

        // T4: timeout at 20, then HALT on the timeout cycle
        NUM_INST = 16'h0300;
        start_run();
        for (int i = 0; i < 18; i++) tick();
        chk("t4_busy18", a_busy, 1);
        tick();
        chk("t4_done", a_done, 1);
        chk("t4_to", a_to, 1);
        chk("t4_cyc", a_cyc, 19);
        chk("t4_miss", a_miss, 0);
        start_run();
        for (int i = 0; i < 18; i++) tick();
        drive(16'h0300, 16'h0000, 1);
        chk("t4h_done", a_done, 1);
        chk("t4h_to", a_to, 0);
        chk("t4h_cyc", a_cyc, 19);
        chk("t4h_miss", a_miss, 1);

        // CYCLE saturation in the no-timeout instance
        start_run();
        for (int i = 0; i < 260; i++) tick();
        chk("sat_busy", b_busy, 1);
        chk("sat_cyc", b_cyc, 8'hff);
        drive(16'h0300, 16'h0000, 1);
        chk("sat_cyc_done", b_cyc, 8'hff);

        // T5: two entries hit in one cycle, third never reached
        wr(0, 16'h0010, 16'h0001);
        wr(1, 16'h0010, 16'h0001);
        wr(2, 16'h0021, 16'h0005);
        start_run();
        drive(16'h0010, 16'h0001, 0);
        chk("t5_pcnt2", a_pcnt, 2);
        drive(16'h0011, 16'h0001, 1);
        chk("t5_done", a_done, 1);
        chk("t5_miss", a_miss, 1);
        chk("t5_pass", a_pass, 0);
        chk("t5_fail", a_fail, 0);

        // T6: table write during RUN is dropped
        start_run();
        NUM_INST = 16'h0300; OUTPUT_PORT = 16'h0300;
        wr(0, 16'h0300, 16'h0300);
        tick();
        chk("t6_we_drop", a_pcnt, 0);
        drive(16'h0300, 16'h0300, 1);
        chk("t6_miss", a_miss, 1);
        chk("t6_pcnt", a_pcnt, 0);
        start_run();
        chk("t6_rerun_busy", a_busy, 1);
        chk("t6_rerun_cyc0", a_cyc, 0);
        tick(); tick();
        chk("t6_rerun_cyc2", a_cyc, 2);
        RSTn = 1'b0;
        tick();
        chk("t6_rst_busy", a_busy, 0);
        chk("t6_rst_done", a_done, 0);
        chk("t6_rst_pass", a_pass, 0);
        chk("t6_rst_fail", a_fail, 0);
        chk("t6_rst_miss", a_miss, 0);
        chk("t6_rst_to", a_to, 0);
        chk("t6_rst_pcnt", a_pcnt, 0);
        chk("t6_rst_cyc", a_cyc, 0);
        RSTn = 1'b1;

        // Empty table after reset: HALT gives PASS with zero count
        start_run();
        drive(16'h0300, 16'h0000, 1);
        chk("empty_pass", a_pass, 1);
        chk("empty_pcnt", a_pcnt, 0);
        chk("empty_miss", a_miss, 0);

        // Write and START in the same cycle: the run sees the new entry
        TBL_WE = 1'b1; TBL_IDX = 0; TBL_NUM_INST = 16'h0005; TBL_ANS = 16'h0007; START = 1'b1;
        tick();
        TBL_WE = 1'b0; START = 1'b0;
        drive(16'h0005, 16'h0007, 0);
        chk("wrst_pcnt", a_pcnt, 1);
        drive(16'h0006, 16'h0000, 1);
        chk("wrst_pass", a_pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
